// File: rtl/debug_uart_ctrl.sv
// debug_uart_ctrl
//   Command sequencer between the debug UART FIFOs and the MIPS pipeline.
//   Pops command bytes from the RX FIFO and then does one of the following:
//   loads instruction memory, single-steps the CPU, free-runs the CPU until it
//   halts, or streams the register file back through the TX FIFO.
//   This block is the only user of both FIFO ports.
//
// Ports
//   clk, reset          clock; asynchronous active-low reset
//   rx_empty, r_data    RX FIFO status and head byte (first-word fall-through)
//   rd_uart             RX pop strobe
//   tx_full             TX FIFO full
//   wr_uart, w_data     TX push strobe and byte
//   im_we/addr/wdata    instruction-memory write port
//   cpu_run, cpu_step   free-run level and single-step pulse
//   cpu_halted          CPU has reached HALT
//   dbg_addr, dbg_data  register-file debug read port (combinational data)
//   busy                high in every state except IDLE
//
// Command set (first byte):
//   'L' N w0..wN-1 : load N words (N=0 means 256); replies 'K'
//   'S'            : one step pulse, then a full register dump
//   'R'            : run until halted; replies 'K'
//   'D'            : register dump, 4 bytes per register, MSB first
//   other          : replies '?'
module debug_uart_ctrl #(
    parameter int DBIT  = 8,   // expected to be 8; the low byte of r_data is used
    parameter int IM_AW = 8,
    parameter int NREGS = 32,
    parameter int RA_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_empty,
    input  logic [DBIT-1:0]  r_data,
    output logic             rd_uart,
    input  logic             tx_full,
    output logic             wr_uart,
    output logic [DBIT-1:0]  w_data,
    output logic             im_we,
    output logic [IM_AW-1:0] im_addr,
    output logic [31:0]      im_wdata,
    output logic             cpu_run,
    output logic             cpu_step,
    input  logic             cpu_halted,
    output logic [RA_W-1:0]  dbg_addr,
    input  logic [31:0]      dbg_data,
    output logic             busy
);

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_DUMP = 8'h44;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_BAD  = 8'h3F;

    typedef enum logic [3:0] {
        IDLE, CMD, LOAD_CNT, LOAD_BYTE, LOAD_WR, STEP, RUN,
        DUMP_ADDR, DUMP_LATCH, DUMP_SEND, ACK
    } state_t;

    state_t      state;
    logic        armed;       // low for the first cycle out of reset, keeps rd_uart at 0 during reset
    logic        tx_pend;     // w_data holds a byte that has not been accepted yet
    logic [7:0]  cmd;
    logic [1:0]  byte_idx;
    logic [8:0]  words_left;  // 9 bits so that a count byte of 0 can hold 256
    logic [23:0] dump_sh;     // remaining bytes of the register being sent
    logic [7:0]  rx_byte;
    logic        last_reg;

    assign rx_byte  = r_data[7:0];
    assign last_reg = (dbg_addr == RA_W'(NREGS - 1));

    // The strobes are qualified by the FIFO flags in the same cycle. No pop is
    // issued into an empty FIFO and no push into a full one, whatever the
    // flags did in the previous cycle.
    assign rd_uart = armed && !rx_empty &&
                     (state == IDLE || state == LOAD_CNT || state == LOAD_BYTE);
    assign wr_uart = tx_pend && !tx_full;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            armed      <= 1'b0;
            tx_pend    <= 1'b0;
            cmd        <= '0;
            byte_idx   <= '0;
            words_left <= '0;
            dump_sh    <= '0;
            w_data     <= '0;
            im_we      <= 1'b0;
            im_addr    <= '0;
            im_wdata   <= '0;
            cpu_run    <= 1'b0;
            cpu_step   <= 1'b0;
            dbg_addr   <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: if (rd_uart) begin
                    cmd   <= rx_byte;
                    state <= CMD;
                end

                CMD: case (cmd)
                    CMD_LOAD: begin
                        im_addr <= '0;
                        state   <= LOAD_CNT;
                    end
                    CMD_STEP: begin
                        cpu_step <= 1'b1;
                        state    <= STEP;
                    end
                    CMD_RUN: begin
                        // If the CPU is already halted, cpu_run never asserts.
                        if (cpu_halted) begin
                            w_data  <= DBIT'(RSP_OK);
                            tx_pend <= 1'b1;
                            state   <= ACK;
                        end else begin
                            cpu_run <= 1'b1;
                            state   <= RUN;
                        end
                    end
                    CMD_DUMP: begin
                        dbg_addr <= '0;
                        state    <= DUMP_ADDR;
                    end
                    default: begin
                        w_data  <= DBIT'(RSP_BAD);
                        tx_pend <= 1'b1;
                        state   <= ACK;
                    end
                endcase

                LOAD_CNT: if (rd_uart) begin
                    words_left <= (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
                    byte_idx   <= '0;
                    state      <= LOAD_BYTE;
                end

                // Assemble the word directly in im_wdata. A stall on an empty
                // RX FIFO keeps the bytes received so far.
                LOAD_BYTE: if (rd_uart) begin
                    im_wdata <= {im_wdata[23:0], rx_byte};
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        im_we <= 1'b1;
                        state <= LOAD_WR;
                    end
                end

                LOAD_WR: begin
                    im_we      <= 1'b0;
                    im_addr    <= im_addr + 1'b1;
                    words_left <= words_left - 9'd1;
                    if (words_left == 9'd1) begin
                        w_data  <= DBIT'(RSP_OK);
                        tx_pend <= 1'b1;
                        state   <= ACK;
                    end else begin
                        state <= LOAD_BYTE;
                    end
                end

                STEP: begin
                    cpu_step <= 1'b0;
                    dbg_addr <= '0;
                    state    <= DUMP_ADDR;
                end

                RUN: if (cpu_halted) begin
                    cpu_run <= 1'b0;
                    w_data  <= DBIT'(RSP_OK);
                    tx_pend <= 1'b1;
                    state   <= ACK;
                end

                DUMP_ADDR: state <= DUMP_LATCH;

                DUMP_LATCH: begin
                    w_data   <= DBIT'(dbg_data[31:24]);
                    dump_sh  <= dbg_data[23:0];
                    byte_idx <= '0;
                    tx_pend  <= 1'b1;
                    state    <= DUMP_SEND;
                end

                DUMP_SEND: if (wr_uart) begin
                    if (byte_idx == 2'd3) begin
                        tx_pend <= 1'b0;
                        if (last_reg) begin
                            state <= IDLE;
                        end else begin
                            dbg_addr <= dbg_addr + 1'b1;
                            state    <= DUMP_ADDR;
                        end
                    end else begin
                        w_data   <= DBIT'(dump_sh[23:16]);
                        dump_sh  <= {dump_sh[15:0], 8'h00};
                        byte_idx <= byte_idx + 2'd1;
                    end
                end

                ACK: if (wr_uart) begin
                    tx_pend <= 1'b0;
                    state   <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_uart_ctrl.sv
// Self-checking bench for debug_uart_ctrl. The RX and TX FIFOs and the
// register file are modelled here. Expected TX bytes and instruction-memory
// writes come from a byte-level command interpreter.
module tb_debug_uart_ctrl;

    localparam int NREGS = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_empty = 1'b1;
    logic [7:0]  r_data = 8'h00;
    logic        tx_full = 1'b0;
    logic        cpu_halted = 1'b0;
    logic        rd_uart, wr_uart, im_we, cpu_run, cpu_step, busy;
    logic [7:0]  w_data, im_addr;
    logic [31:0] im_wdata, dbg_data;
    logic [4:0]  dbg_addr;

    logic [31:0] rf [NREGS];
    assign dbg_data = rf[dbg_addr];

    int checks = 0;
    int errors = 0;

    logic [7:0]  rx_q[$], tx_got[$], stim[$], exp_tx[$];
    logic [39:0] im_log[$], exp_im[$];
    int step_cnt = 0, exp_steps = 0, run_cycles = 0;
    int cyc = 0, pop_cyc = 0, step_cyc = 0;
    bit txfull_rand = 0;

    debug_uart_ctrl #(.DBIT(8), .IM_AW(8), .NREGS(NREGS), .RA_W(5)) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
        .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .cpu_run(cpu_run), .cpu_step(cpu_step), .cpu_halted(cpu_halted),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Drive the FIFO flags away from the active edge.
    always @(negedge clk) begin
        tx_full  = txfull_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        rx_empty = (rx_q.size() == 0);
        r_data   = rx_empty ? 8'h00 : rx_q[0];
    end

    // Sample the strobes at the edge on which they take effect.
    always @(posedge clk) begin
        logic [7:0] tmp;
        cyc++;
        if (reset) begin
            if (int'(rd_uart) + int'(wr_uart) + int'(im_we) + int'(cpu_step) > 1) begin
                errors++;
                $display("FAIL strobe_exclusive: rd=%0b wr=%0b we=%0b step=%0b, at most one allowed",
                         rd_uart, wr_uart, im_we, cpu_step);
            end
            if (rd_uart) begin
                if (rx_empty || rx_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_pop_empty: rd_uart=1 with rx_empty=%0b", rx_empty);
                end else tmp = rx_q.pop_front();
                pop_cyc = cyc;
            end
            if (wr_uart) begin
                if (tx_full) begin
                    errors++;
                    $display("FAIL tx_push_full: wr_uart=1 with tx_full=1");
                end
                tx_got.push_back(w_data);
            end
            if (im_we) im_log.push_back({im_addr, im_wdata});
            if (cpu_step) begin
                step_cnt++;
                step_cyc = cyc;
            end
            if (cpu_run) run_cycles++;
        end
    end

    // Reference interpreter: expand a complete command byte stream into the
    // TX bytes and memory writes that it must produce.
    task automatic run_model();
        int i = 0;
        int n;
        logic [7:0]  c, a;
        logic [31:0] w;
        while (i < stim.size()) begin
            c = stim[i]; i++;
            if (c == 8'h4C) begin
                n = int'(stim[i]); i++;
                if (n == 0) n = 256;
                a = 8'h00;
                for (int k = 0; k < n; k++) begin
                    w = {stim[i], stim[i+1], stim[i+2], stim[i+3]};
                    i += 4;
                    exp_im.push_back({a, w});
                    a++;
                end
                exp_tx.push_back(8'h4B);
            end else if (c == 8'h53 || c == 8'h44) begin
                if (c == 8'h53) exp_steps++;
                for (int r = 0; r < NREGS; r++)
                    for (int b = 3; b >= 0; b--) exp_tx.push_back(rf[r][8*b +: 8]);
            end else if (c == 8'h52) begin
                exp_tx.push_back(8'h4B);
            end else begin
                exp_tx.push_back(8'h3F);
            end
        end
    endtask

    task automatic clear_logs();
        tx_got.delete(); im_log.delete(); exp_tx.delete(); exp_im.delete(); stim.delete();
        step_cnt = 0; exp_steps = 0; run_cycles = 0;
    endtask

    task automatic push_stim(input int from, input int to);
        for (int i = from; i < to; i++) rx_q.push_back(stim[i]);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        ok = 0;
        repeat (3) @(negedge clk);
        while (n < budget) begin
            @(negedge clk);
            if (rx_q.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
            n++;
        end
        repeat (3) @(negedge clk);
    endtask

    function automatic int tx_mismatch();
        int n = (tx_got.size() < exp_tx.size()) ? tx_got.size() : exp_tx.size();
        for (int i = 0; i < n; i++) if (tx_got[i] !== exp_tx[i]) return i;
        if (tx_got.size() != exp_tx.size()) return n;
        return -1;
    endfunction

    function automatic int im_mismatch();
        int n = (im_log.size() < exp_im.size()) ? im_log.size() : exp_im.size();
        for (int i = 0; i < n; i++) if (im_log[i] !== exp_im[i]) return i;
        if (im_log.size() != exp_im.size()) return n;
        return -1;
    endfunction

    task automatic test_reset();
        logic [58:0] outs;
        #2;
        outs = {rd_uart, wr_uart, im_we, cpu_run, cpu_step, busy, w_data, im_addr, im_wdata, dbg_addr};
        checks++;
        if (outs !== 59'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, need 0", outs);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, rd_uart, wr_uart} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release_idle: busy/rd/wr=%b, need 000", {busy, rd_uart, wr_uart});
        end
    endtask

    task automatic test_load();
        bit ok;
        int m;
        clear_logs();
        stim = '{8'h4C, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01};
        run_model();
        push_stim(0, stim.size());
        wait_done(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL load2_timeout: still busy, need idle"); end
        checks++;
        if (im_log.size() != 2 || im_log[0] !== {8'h00, 32'hDEADBEEF} || im_log[1] !== {8'h01, 32'h00000001}) begin
            errors++;
            $display("FAIL load2_writes: got %0d writes, need 00:DEADBEEF 01:00000001", im_log.size());
        end
        m = tx_mismatch();
        checks++;
        if (m != -1) begin errors++; $display("FAIL load2_tx: got %0d bytes, need %0d (first diff %0d)", tx_got.size(), exp_tx.size(), m); end
        checks++;
        if (im_addr !== 8'd2) begin errors++; $display("FAIL load2_addr: got %0d, need 2", im_addr); end

        // A count byte of 0 loads 256 words, which fills and wraps the address space.
        clear_logs();
        txfull_rand = 1;
        stim.push_back(8'h4C); stim.push_back(8'h00);
        for (int i = 0; i < 1024; i++) stim.push_back(8'($urandom));
        run_model();
        push_stim(0, stim.size());
        wait_done(6000, ok);
        txfull_rand = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL load256_timeout: still busy, need idle"); end
        m = im_mismatch();
        checks++;
        if (m != -1) begin errors++; $display("FAIL load256_im: got %0d writes, need %0d (first diff %0d)", im_log.size(), exp_im.size(), m); end
        m = tx_mismatch();
        checks++;
        if (m != -1) begin errors++; $display("FAIL load256_tx: got %0d bytes, need %0d (first diff %0d)", tx_got.size(), exp_tx.size(), m); end
        checks++;
        if (im_addr !== 8'd0) begin errors++; $display("FAIL load256_wrap: im_addr got %0d, need 0", im_addr); end
    endtask

    task automatic test_dump();
        bit ok;
        int m;
        clear_logs();
        for (int r = 0; r < NREGS; r++) rf[r] = r * 32'h01010101;
        txfull_rand = 1;
        stim = '{8'h44};
        run_model();
        push_stim(0, 1);
        wait_done(3000, ok);
        txfull_rand = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL dump_timeout: still busy, need idle"); end
        checks++;
        if (tx_got.size() != 128) begin errors++; $display("FAIL dump_count: got %0d bytes, need 128", tx_got.size()); end
        checks++;
        if (tx_got.size() >= 24 && {tx_got[20], tx_got[21], tx_got[22], tx_got[23]} !== 32'h05050505) begin
            errors++;
            $display("FAIL dump_reg5: got %h%h%h%h, need 05050505", tx_got[20], tx_got[21], tx_got[22], tx_got[23]);
        end
        m = tx_mismatch();
        checks++;
        if (m != -1) begin errors++; $display("FAIL dump_stream: first diff at byte %0d", m); end
    endtask

    task automatic test_run();
        bit ok;
        int n = 0;
        clear_logs();
        cpu_halted = 1'b0;
        stim = '{8'h52};
        run_model();
        push_stim(0, 1);
        @(negedge clk);
        while (!cpu_run && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!cpu_run) begin errors++; $display("FAIL run_start: cpu_run got 0, need 1"); end
        repeat (9) @(negedge clk);
        cpu_halted = 1'b1;
        wait_done(100, ok);
        checks++;
        if (!ok || cpu_run !== 1'b0) begin errors++; $display("FAIL run_stop: cpu_run=%0b idle=%0b, need 0/1", cpu_run, ok); end
        checks++;
        if (run_cycles != 10) begin errors++; $display("FAIL run_length: got %0d cycles, need 10", run_cycles); end
        checks++;
        if (tx_mismatch() != -1) begin errors++; $display("FAIL run_tx: got %0d bytes, need one 4B", tx_got.size()); end

        // The CPU is already halted when 'R' arrives.
        clear_logs();
        stim = '{8'h52};
        run_model();
        push_stim(0, 1);
        wait_done(100, ok);
        checks++;
        if (run_cycles != 0 || tx_mismatch() != -1) begin
            errors++;
            $display("FAIL run_prehalted: run cycles %0d, tx bytes %0d, need 0 cycles and one 4B", run_cycles, tx_got.size());
        end
        cpu_halted = 1'b0;
    endtask

    task automatic test_step();
        bit ok;
        clear_logs();
        for (int r = 0; r < NREGS; r++) rf[r] = $urandom;
        stim = '{8'h53};
        run_model();
        push_stim(0, 1);
        wait_done(1000, ok);
        checks++;
        if (!ok || step_cnt != exp_steps) begin errors++; $display("FAIL step_pulse: got %0d pulses, need %0d", step_cnt, exp_steps); end
        checks++;
        if (step_cyc - pop_cyc != 2) begin errors++; $display("FAIL step_latency: got %0d cycles, need 2", step_cyc - pop_cyc); end
        checks++;
        if (tx_mismatch() != -1) begin errors++; $display("FAIL step_dump: got %0d bytes, need %0d", tx_got.size(), exp_tx.size()); end
    endtask

    task automatic test_bad_and_stall();
        bit ok;
        clear_logs();
        stim = '{8'h7A};
        run_model();
        push_stim(0, 1);
        wait_done(100, ok);
        checks++;
        if (!ok || tx_mismatch() != -1) begin errors++; $display("FAIL bad_cmd: got %0d bytes (first %h), need one 3F", tx_got.size(), tx_got.size() ? tx_got[0] : 8'h00); end

        // A byte of the word arrives, then nothing for 50 cycles.
        clear_logs();
        stim = '{8'h4C, 8'h01, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        run_model();
        push_stim(0, 3);
        repeat (50) @(negedge clk);
        checks++;
        if (!busy || im_log.size() != 0) begin errors++; $display("FAIL stall_hold: busy=%0b writes=%0d, need 1/0", busy, im_log.size()); end
        push_stim(3, 6);
        wait_done(100, ok);
        checks++;
        if (!ok || im_mismatch() != -1) begin
            errors++;
            $display("FAIL stall_word: got %0d writes (%h), need %h", im_log.size(), im_log.size() ? im_log[0] : 40'h0, exp_im[0]);
        end
        checks++;
        if (tx_mismatch() != -1) begin errors++; $display("FAIL stall_tx: got %0d bytes, need one 4B", tx_got.size()); end
    endtask

    task automatic test_reset_mid_dump();
        logic [58:0] outs;
        int n = 0;
        clear_logs();
        for (int r = 0; r < NREGS; r++) rf[r] = $urandom;
        txfull_rand = 1;
        rx_q.push_back(8'h44);
        while (tx_got.size() < 20 && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (tx_got.size() < 20) begin errors++; $display("FAIL reset_dump_progress: got %0d bytes, need 20", tx_got.size()); end
        #2 reset = 1'b0;
        #1;
        outs = {rd_uart, wr_uart, im_we, cpu_run, cpu_step, busy, w_data, im_addr, im_wdata, dbg_addr};
        checks++;
        if (outs !== 59'd0) begin errors++; $display("FAIL reset_dump_outputs: got %h, need 0", outs); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        n = tx_got.size();
        repeat (60) @(negedge clk);
        txfull_rand = 0;
        checks++;
        if (tx_got.size() != n || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_dump_quiet: got %0d extra bytes busy=%0b, need 0/0", tx_got.size() - n, busy);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        logic [7:0] b;
        cpu_halted = 1'b1;
        for (int round = 0; round < 3; round++) begin
            clear_logs();
            for (int r = 0; r < NREGS; r++) rf[r] = $urandom;
            txfull_rand = 1;
            for (int k = 0; k < 6; k++) begin
                case ($urandom_range(0, 4))
                    0: begin
                        n = $urandom_range(1, 3);
                        stim.push_back(8'h4C); stim.push_back(8'(n));
                        for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
                    end
                    1: stim.push_back(8'h53);
                    2: stim.push_back(8'h44);
                    3: stim.push_back(8'h52);
                    default: begin
                        do b = 8'($urandom);
                        while (b == 8'h4C || b == 8'h53 || b == 8'h52 || b == 8'h44);
                        stim.push_back(b);
                    end
                endcase
            end
            run_model();
            push_stim(0, stim.size());
            wait_done(10000, ok);
            checks++;
            if (!ok || tx_mismatch() != -1) begin
                errors++;
                $display("FAIL b2b_tx round %0d: got %0d bytes, need %0d (first diff %0d)", round, tx_got.size(), exp_tx.size(), tx_mismatch());
            end
            checks++;
            if (im_mismatch() != -1 || step_cnt != exp_steps) begin
                errors++;
                $display("FAIL b2b_im round %0d: writes %0d/%0d steps %0d/%0d", round, im_log.size(), exp_im.size(), step_cnt, exp_steps);
            end
        end
        txfull_rand = 0;
        cpu_halted = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < NREGS; r++) rf[r] = 32'h0;
        test_reset();
        test_load();
        test_dump();
        test_run();
        test_step();
        test_bad_and_stall();
        test_reset_mid_dump();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
